alu_cmd_issuer: RTL

- Initiator end of the ALU command interface.
- Accepts operations from a host port and packs each into the 10-bit command word `{op[1:0], b[3:0], a[3:0]}`. Drives the word into the ALU pipeline input FIFO with a valid/ready handshake.
- Receives 9-bit results from the output FIFO and checks each, in order, against an internally computed expected value.
- Sits between the test/host logic and the FIFO→ALU→FIFO datapath top.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_exp_fifo.sv | 52 +++++
 rtl/alu_cmd_issuer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command interface.
//   - alu_op_e      : opcode encoding (ADD/SUB/MUL/DIV)
//   - issue_state_t : issuer FSM state encoding
//   - CMD_W/RES_W   : command and result widths
//   - A_LSB/B_LSB/OP_LSB : field positions inside the command word
//   - alu_expect()  : returns {dont_check, 9-bit expected result}
package alu_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned RES_W  = 9;
  localparam int unsigned A_LSB  = 0;
  localparam int unsigned B_LSB  = 4;
  localparam int unsigned OP_LSB = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } issue_state_t;

  // Bit RES_W is the don't-check flag (divide by zero); bits RES_W-1:0 the value.
  function automatic logic [RES_W:0] alu_expect(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input alu_op_e    op);
    logic [RES_W-1:0] v;
    logic             dc;
    v  = '0;
    dc = 1'b0;
    case (op)
      OP_ADD: v = RES_W'(a) + RES_W'(b);
      OP_SUB: v = RES_W'(a) - RES_W'(b);
      OP_MUL: v = RES_W'(a) * RES_W'(b);
      OP_DIV: begin
        if (b == 4'd0) dc = 1'b1;
        else           v  = RES_W'(a / b);
      end
      default: v = '0;
    endcase
    return {dc, v};
  endfunction

endpackage

// File: rtl/alu_exp_fifo.sv
// alu_exp_fifo: circular scoreboard of expected results.
//   clk, rst      : clock, async active-high reset (empties the buffer)
//   i_push/i_data : write an entry (accepted when not full, or when popping)
//   i_pop/o_data  : o_data is the head; i_pop removes it when not empty
//   o_full/o_empty/o_count : occupancy status
module alu_exp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count   = r_wr - r_rd;
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // When full, a simultaneous pop frees the head slot that the push overwrites.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator end of the ALU command interface.
//   clk, reset                 : clock, async active-high reset
//   host_valid/ready/a/b/op    : host operation input
//   req_data/valid/ready       : packed command {op,b,a} to the ALU input FIFO
//   rsp_data/valid/ready       : 9-bit results from the ALU output FIFO
//   outstanding                : commands issued but not yet answered
//   pass_cnt/fail_cnt          : saturating result-check counters
//   err_unexpected             : sticky, result with empty scoreboard
//   timeout                    : sticky watchdog flag
// Optional macro ALU_CMD_ISSUER_TIMEOUT_EN enables the response watchdog.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [3:0]                 host_a,
  input  logic [3:0]                 host_b,
  input  logic [1:0]                 host_op,
  output logic [9:0]                 req_data,
  output logic                       req_valid,
  input  logic                       req_ready,
  input  logic [8:0]                 rsp_data,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic [15:0]                pass_cnt,
  output logic [15:0]                fail_cnt,
  output logic                       err_unexpected,
  output logic                       timeout
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  issue_state_t     r_state;
  issue_state_t     w_state_nxt;
  logic [CMD_W-1:0] r_req_data;
  logic [CNT_W-1:0] r_outstanding;
  logic [15:0]      r_pass;
  logic [15:0]      r_fail;
  logic             r_err;
  logic             w_timeout;

  logic             w_host_fire;
  logic             w_req_fire;
  logic             w_rsp_fire;
  logic [CMD_W-1:0] w_cmd;
  logic [RES_W:0]   w_exp;
  logic [RES_W:0]   w_head;
  logic             w_sb_full;
  logic             w_sb_empty;
  logic [CNT_W-1:0] w_sb_count;
  logic             w_push;

  assign w_host_fire = host_valid && host_ready;
  assign w_req_fire  = req_valid && req_ready;
  assign w_rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    w_cmd = '0;
    w_cmd[A_LSB +: 4]  = host_a;
    w_cmd[B_LSB +: 4]  = host_b;
    w_cmd[OP_LSB +: 2] = host_op;
  end

  assign w_exp  = alu_expect(host_a, host_b, alu_op_e'(host_op));
  assign w_push = w_host_fire && !w_sb_full;

  alu_exp_fifo #(
    .DEPTH (DEPTH),
    .W     (RES_W + 1)
  ) u_sb (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (w_exp),
    .i_pop   (w_rsp_fire),
    .o_data  (w_head),
    .o_full  (w_sb_full),
    .o_empty (w_sb_empty),
    .o_count (w_sb_count)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_host_fire) w_state_nxt = ST_SEND;
      ST_SEND: if (req_ready)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. The scoreboard count equals outstanding plus any pending
  // command, so it is the admission test.
  always_comb begin
    req_valid  = (r_state == ST_SEND);
    rsp_ready  = !reset;
    host_ready = !reset && (r_state == ST_IDLE) && (w_sb_count < DEPTH_C) && !w_timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_req_data <= '0;
    else if (w_host_fire) r_req_data <= w_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_req_fire, w_rsp_fire && (r_outstanding != '0)})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass <= '0;
      r_fail <= '0;
      r_err  <= 1'b0;
    end else if (w_rsp_fire) begin
      if (w_sb_empty) begin
        r_err <= 1'b1;
      end else if (!w_head[RES_W]) begin
        if (w_head[RES_W-1:0] == rsp_data) begin
          if (r_pass != 16'hFFFF) r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail != 16'hFFFF) r_fail <= r_fail + 1'b1;
        end
      end
    end
  end

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
  localparam logic [15:0] TO_C = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_wd;
  logic        r_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_rsp_fire || (r_outstanding == '0)) begin
      r_wd <= '0;
    end else begin
      if (r_wd != 16'hFFFF) r_wd <= r_wd + 1'b1;
      // r_wd holds cycles already waited; this edge completes one more.
      if (r_wd >= TO_C - 16'd1) r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  assign req_data       = r_req_data;
  assign outstanding    = r_outstanding;
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign err_unexpected = r_err;
  assign timeout        = w_timeout;

endmodule
